// File: rtl/event_pkg.sv
// event_pkg
//   Shared definitions for the event-report stream. Both the event
//   transmitter and the event decoder import this package, so event
//   codes and the beat marker are defined in exactly one place.
//   No ports (package).
package event_pkg;

  // Number of distinct event codes carried on the stream (codes 1..EVENT_TYPES).
  localparam int EVENT_TYPES = 3;

  // Value carried in TDATA[255:248] of every well-formed beat.
  localparam logic [7:0] EVENT_MARKER = 8'h01;

  // Event codes as they appear in TDATA[7:0]. Code k maps to index k-1.
  localparam logic [7:0] EVT_CODE_UNDERFLOW = 8'd1;
  localparam logic [7:0] EVT_CODE_A         = 8'd2;
  localparam logic [7:0] EVT_CODE_B         = 8'd3;

endpackage

// File: rtl/event_decoder_sat_counter.sv
// sat_counter
//   Saturating event counter with a synchronous clear. A clear that lands
//   in the same cycle as an increment leaves the counter at 1, so the
//   coincident event is never lost.
// Ports:
//   clk    in   clock
//   resetn in   synchronous active-low reset (counter -> 0)
//   inc    in   increment request (ignored once the counter is full)
//   clr    in   clear request
//   count  out  current count, CNT_WIDTH bits
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_full;

  assign w_full = &r_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= CNT_WIDTH'(inc);
    end else if (inc && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/event_decoder.sv
// event_decoder
//   Receiving end of the 256-bit event-report AXI stream. Validates the
//   marker and event code of each beat, raises a one-cycle strobe per event
//   type, keeps sticky pending bits and per-type saturating counters, and
//   drives a maskable interrupt. Never backpressures; one register stage.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   AXIS_IN_TDATA/TVALID event beat in; TREADY out (high after reset)
//   event_strobe         one-cycle pulse per decoded event
//   event_pending        sticky per-type flags, pending_ack clears (W1C)
//   irq_mask, irq        irq = registered OR of (pending & mask)
//   cnt_sel, cnt_out     registered counter readback (EVENT_TYPES = errors)
//   clear_counters       zero all counters
//   last_code            code of the most recent valid event
//   bad_beat             one-cycle pulse on a rejected beat
module event_decoder
  import event_pkg::*;
#(
  parameter int         EVENT_TYPES = event_pkg::EVENT_TYPES,
  parameter int         CNT_WIDTH   = 32,
  parameter logic [7:0] MARKER      = event_pkg::EVENT_MARKER,
  localparam int        SEL_W       = $clog2(EVENT_TYPES + 1)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [255:0]           AXIS_IN_TDATA,
  input  logic                   AXIS_IN_TVALID,
  output logic                   AXIS_IN_TREADY,
  output logic [EVENT_TYPES-1:0] event_strobe,
  output logic [EVENT_TYPES-1:0] event_pending,
  input  logic [EVENT_TYPES-1:0] pending_ack,
  input  logic [EVENT_TYPES-1:0] irq_mask,
  output logic                   irq,
  input  logic [SEL_W-1:0]       cnt_sel,
  output logic [CNT_WIDTH-1:0]   cnt_out,
  input  logic                   clear_counters,
  output logic [7:0]             last_code,
  output logic                   bad_beat
);

  logic                   r_tready;
  logic [EVENT_TYPES-1:0] r_strobe;
  logic [EVENT_TYPES-1:0] r_pending;
  logic                   r_irq;
  logic [CNT_WIDTH-1:0]   r_cnt_out;
  logic [7:0]             r_last_code;
  logic                   r_bad;

  logic                   w_accept;
  logic [7:0]             w_code;
  logic                   w_marker_ok;
  logic                   w_code_ok;
  logic                   w_valid;
  logic                   w_bad;
  logic [EVENT_TYPES-1:0] w_hit;
  logic [EVENT_TYPES:0]   w_inc;
  logic [CNT_WIDTH-1:0]   w_count [0:EVENT_TYPES];
  logic [CNT_WIDTH-1:0]   w_cnt_mux;
  logic                   w_unused_tdata;

  // Payload bits between the code and the marker carry nothing for us.
  assign w_unused_tdata = ^AXIS_IN_TDATA[247:8];

  assign w_accept    = AXIS_IN_TVALID && r_tready;
  assign w_code      = AXIS_IN_TDATA[7:0];
  assign w_marker_ok = (AXIS_IN_TDATA[255:248] == MARKER);
  assign w_code_ok   = (w_code != 8'd0) && (w_code <= 8'(EVENT_TYPES));
  assign w_valid     = w_accept && w_marker_ok && w_code_ok;
  assign w_bad       = w_accept && !(w_marker_ok && w_code_ok);

  // One-hot decode: code k lights index k-1.
  genvar gi;
  generate
    for (gi = 0; gi < EVENT_TYPES; gi++) begin : g_hit
      assign w_hit[gi] = w_valid && (w_code == 8'(gi + 1));
    end
  endgenerate

  // Top counter slot counts rejected beats.
  assign w_inc = {w_bad, w_hit};

  generate
    for (gi = 0; gi <= EVENT_TYPES; gi++) begin : g_cnt
      sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (w_inc[gi]),
        .clr    (clear_counters),
        .count  (w_count[gi])
      );
    end
  endgenerate

  // Any select value with no matching counter reads as zero.
  always_comb begin
    w_cnt_mux = '0;
    for (int i = 0; i <= EVENT_TYPES; i++) begin
      if (cnt_sel == SEL_W'(i)) begin
        w_cnt_mux = w_count[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tready    <= 1'b0;
      r_strobe    <= '0;
      r_pending   <= '0;
      r_irq       <= 1'b0;
      r_cnt_out   <= '0;
      r_last_code <= 8'd0;
      r_bad       <= 1'b0;
    end else begin
      r_tready  <= 1'b1;
      r_strobe  <= w_hit;
      // Set wins over a coincident acknowledge on the same bit.
      r_pending <= (r_pending & ~pending_ack) | w_hit;
      // Built from the registered pending bits, hence two cycles from beat.
      r_irq     <= |(r_pending & irq_mask);
      r_cnt_out <= w_cnt_mux;
      r_bad     <= w_bad;
      if (w_valid) begin
        r_last_code <= w_code;
      end
    end
  end

  assign AXIS_IN_TREADY = r_tready;
  assign event_strobe   = r_strobe;
  assign event_pending  = r_pending;
  assign irq            = r_irq;
  assign cnt_out        = r_cnt_out;
  assign last_code      = r_last_code;
  assign bad_beat       = r_bad;

endmodule

// File: tb/tb_event_decoder.sv
// tb_event_decoder
//   Directed bench for event_decoder (CNT_WIDTH=4 so saturation is reachable).
//   Each cycle a reference model predicts every output; the prediction is
//   pushed to a scoreboard queue before the edge and popped and compared
//   after it.
module tb_event_decoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [255:0]  tdata;
  logic          tvalid;
  logic          tready;
  logic [2:0]    event_strobe;
  logic [2:0]    event_pending;
  logic [2:0]    pending_ack;
  logic [2:0]    irq_mask;
  logic          irq;
  logic [1:0]    cnt_sel;
  logic [CW-1:0] cnt_out;
  logic          clear_counters;
  logic [7:0]    last_code;
  logic          bad_beat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          ready;
    logic [2:0]    strobe;
    logic [2:0]    pending;
    logic          irq;
    logic [CW-1:0] cnt;
    logic [7:0]    last;
    logic          bad;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic          m_ready;
  logic [2:0]    m_pending;
  logic [7:0]    m_last;
  logic [CW-1:0] m_cnt [0:3];

  event_decoder #(
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .AXIS_IN_TDATA  (tdata),
    .AXIS_IN_TVALID (tvalid),
    .AXIS_IN_TREADY (tready),
    .event_strobe   (event_strobe),
    .event_pending  (event_pending),
    .pending_ack    (pending_ack),
    .irq_mask       (irq_mask),
    .irq            (irq),
    .cnt_sel        (cnt_sel),
    .cnt_out        (cnt_out),
    .clear_counters (clear_counters),
    .last_code      (last_code),
    .bad_beat       (bad_beat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] marker, input logic [7:0] code);
    tdata  = {marker, 240'h0, code};
    tvalid = 1'b1;
  endtask

  // Predict the outputs after the next edge, advance one cycle, compare.
  task automatic tick(input string tag);
    exp_t       e;
    logic       acc;
    logic       vld;
    logic [2:0] hit;
    logic [3:0] inc;
    logic [7:0] code;
    code  = tdata[7:0];
    e.cnt = m_cnt[cnt_sel];
    e.irq = |(m_pending & irq_mask);
    if (!resetn) begin
      m_ready   = 1'b0;
      m_pending = 3'b000;
      m_last    = 8'd0;
      for (int i = 0; i < 4; i++) m_cnt[i] = '0;
      e.ready = 1'b0; e.strobe = 3'b000; e.pending = 3'b000;
      e.irq = 1'b0; e.cnt = '0; e.last = 8'd0; e.bad = 1'b0;
    end else begin
      acc = tvalid && m_ready;
      vld = acc && (tdata[255:248] == 8'h01) && (code >= 8'd1) && (code <= 8'd3);
      hit = vld ? (3'b001 << (code - 8'd1)) : 3'b000;
      inc = {acc && !vld, hit};
      for (int i = 0; i < 4; i++) begin
        if (clear_counters) m_cnt[i] = inc[i] ? CW'(1) : CW'(0);
        else if (inc[i] && m_cnt[i] != {CW{1'b1}}) m_cnt[i] = m_cnt[i] + 1'b1;
      end
      m_pending = (m_pending & ~pending_ack) | hit;
      if (vld) m_last = code;
      m_ready   = 1'b1;
      e.ready = 1'b1; e.strobe = hit; e.pending = m_pending;
      e.last = m_last; e.bad = acc && !vld;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_tready"},  tready,        e.ready);
      chk({tag, "_strobe"},  event_strobe,  e.strobe);
      chk({tag, "_pending"}, event_pending, e.pending);
      chk({tag, "_irq"},     irq,           e.irq);
      chk({tag, "_cnt_out"}, cnt_out,       e.cnt);
      chk({tag, "_last"},    last_code,     e.last);
      chk({tag, "_bad"},     bad_beat,      e.bad);
    end
    $display("[%0t] %s rdy=%b strb=%b pend=%b irq=%b cnt[%0d]=%0d last=%0d bad=%b",
             $time, tag, tready, event_strobe, event_pending, irq, cnt_sel, cnt_out,
             last_code, bad_beat);
  endtask

  initial begin
    logic [7:0] seq [0:3];
    resetn = 1'b0; tvalid = 1'b0; tdata = '0; pending_ack = 3'b000;
    irq_mask = 3'b111; cnt_sel = 2'd0; clear_counters = 1'b0;
    m_ready = 1'b0; m_pending = 3'b000; m_last = 8'd0;
    for (int i = 0; i < 4; i++) m_cnt[i] = '0;

    // Reset state and TREADY rising after release
    tick("reset0");
    tick("reset1");
    resetn = 1'b1;
    tick("release");

    // Single code-2 beat, irq two cycles after acceptance
    drive(8'h01, 8'd2);
    tick("t1_beat");
    tvalid = 1'b0;
    cnt_sel = 2'd1;
    tick("t1_irq");
    tick("t1_cnt1");

    // Back-to-back codes 1,2,3,1
    seq[0] = 8'd1; seq[1] = 8'd2; seq[2] = 8'd3; seq[3] = 8'd1;
    for (int i = 0; i < 4; i++) begin
      drive(8'h01, seq[i]);
      tick($sformatf("t2_b2b%0d", i));
    end
    tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cnt_sel = 2'(i);
      tick($sformatf("t2_cnt%0d", i));
    end

    // Bad marker, then out-of-range code
    cnt_sel = 2'd3;
    drive(8'h00, 8'd1);
    tick("t3_badmark");
    drive(8'h01, 8'd4);
    tick("t3_badcode");
    tvalid = 1'b0;
    tick("t3_idle");
    tick("t3_errcnt");

    // Saturation of counter 0
    cnt_sel = 2'd0;
    for (int i = 0; i < 16; i++) begin
      drive(8'h01, 8'd1);
      tick($sformatf("t4_sat%0d", i));
    end
    tvalid = 1'b0;
    tick("t4_hold");

    // Clear coincident with a code-2 beat
    drive(8'h01, 8'd2);
    clear_counters = 1'b1;
    tick("t5_clr_beat");
    clear_counters = 1'b0;
    tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      tick($sformatf("t5_cnt%0d", i));
    end

    // Acknowledge coincident with a set: set wins, other bits clear
    pending_ack = 3'b111;
    drive(8'h01, 8'd2);
    tick("t5_ack_set");
    pending_ack = 3'b000;
    tvalid = 1'b0;
    tick("t5_after");
    // Mask out the pending type, then clear it
    irq_mask = 3'b001;
    tick("t5_mask");
    tick("t5_masked");
    pending_ack = 3'b010;
    tick("t5_ack");
    pending_ack = 3'b000;
    irq_mask = 3'b111;
    tick("t5_clean");

    // Mid-stream reset with a code-3 beat held
    drive(8'h01, 8'd3);
    resetn = 1'b0;
    tick("t6_rst");
    resetn = 1'b1;
    tick("t6_release");
    tvalid = 1'b0;
    cnt_sel = 2'd2;
    tick("t6_idle");
    tick("t6_cnt2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
